// File: rtl/decode_stage.sv
// RV32I OP / OP-IMM decode stage: register file with write bypass, operand
// selection and a single valid/ready output register feeding the ALU.

module decode_stage_rdport #(
  parameter int XLEN = 32
) (
  input  logic [31:0][XLEN-1:0] i_rf,
  input  logic [4:0]            i_addr,
  input  logic                  i_wb_en,
  input  logic [4:0]            i_wb_addr,
  input  logic [XLEN-1:0]       i_wb_data,
  output logic [XLEN-1:0]       o_data
);
  // x0 is hard-wired; a same-cycle writeback to the read address wins over storage
  always_comb begin
    o_data = i_rf[i_addr];
    if (i_addr == 5'd0)
      o_data = '0;
    else if (i_wb_en && (i_wb_addr == i_addr))
      o_data = i_wb_data;
  end
endmodule

module decode_stage #(
  parameter int XLEN          = 32,
  parameter bit RESET_REGFILE = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [2:0]      funct3,
  output logic            funct7,
  output logic [4:0]      rd_addr,
  output logic            illegal
);
  localparam int         NUM_RD    = 2;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  logic [31:0][XLEN-1:0] r_rf;
  logic                  w_we;

  assign w_we = wb_en && (wb_addr != 5'd0);

  generate
    if (RESET_REGFILE) begin : g_rf_rst
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    r_rf <= '0;
        else if (w_we) r_rf[wb_addr] <= wb_data;
      end
    end else begin : g_rf_norst
      always_ff @(posedge clk) begin
        if (w_we) r_rf[wb_addr] <= wb_data;
      end
    end
  endgenerate

  logic [NUM_RD-1:0][4:0]      w_rd_addr;
  logic [NUM_RD-1:0][XLEN-1:0] w_rd_data;

  assign w_rd_addr[0] = instr[19:15];
  assign w_rd_addr[1] = instr[24:20];

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rdport
      decode_stage_rdport #(.XLEN(XLEN)) u_rdport (
        .i_rf      (r_rf),
        .i_addr    (w_rd_addr[gi]),
        .i_wb_en   (wb_en),
        .i_wb_addr (wb_addr),
        .i_wb_data (wb_data),
        .o_data    (w_rd_data[gi])
      );
    end
  endgenerate

  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic            w_is_op, w_is_opimm, w_is_shift;
  logic [XLEN-1:0] w_rs1_d, w_rs2_d;
  logic [2:0]      w_f3_d;
  logic            w_f7_d, w_ill_d;
  logic [4:0]      w_rd_d;

  assign w_opc      = instr[6:0];
  assign w_f3       = instr[14:12];
  assign w_is_op    = (w_opc == OPC_OP);
  assign w_is_opimm = (w_opc == OPC_OPIMM);
  assign w_is_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);

  // Illegal opcodes still flow through, but with every operand/control field zeroed
  always_comb begin
    w_rs1_d = '0;
    w_rs2_d = '0;
    w_f3_d  = '0;
    w_f7_d  = 1'b0;
    w_rd_d  = '0;
    w_ill_d = 1'b1;
    if (w_is_op || w_is_opimm) begin
      w_ill_d = 1'b0;
      w_rs1_d = w_rd_data[0];
      w_f3_d  = w_f3;
      w_rd_d  = instr[11:7];
      if (w_is_op) begin
        w_rs2_d = w_rd_data[1];
        w_f7_d  = instr[30];
      end else begin
        // imm bit 30 only means "arithmetic" for SRAI; ADDI must never become SUB
        w_f7_d  = (w_f3 == 3'b101) && instr[30];
        w_rs2_d = w_is_shift ? {{(XLEN-5){1'b0}}, instr[24:20]}
                             : {{(XLEN-12){instr[31]}}, instr[31:20]};
      end
    end
  end

  logic            r_out_valid;
  logic [XLEN-1:0] r_rs1, r_rs2;
  logic [2:0]      r_f3;
  logic            r_f7, r_ill;
  logic [4:0]      r_rd;
  logic            w_in_ready;

  assign w_in_ready = !r_out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_f3        <= '0;
      r_f7        <= 1'b0;
      r_rd        <= '0;
      r_ill       <= 1'b0;
    end else if (w_in_ready) begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_rs1 <= w_rs1_d;
        r_rs2 <= w_rs2_d;
        r_f3  <= w_f3_d;
        r_f7  <= w_f7_d;
        r_rd  <= w_rd_d;
        r_ill <= w_ill_d;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign rs1_data  = r_rs1;
  assign rs2_data  = r_rs2;
  assign funct3    = r_f3;
  assign funct7    = r_f7;
  assign rd_addr   = r_rd;
  assign illegal   = r_ill;
endmodule
